// File: rtl/note_playback.sv
// Note playback sequencer: fetches entries from a recording memory and holds each one
// on note_out/octave_out for its duration in ticks. Optionally loops the recording.
module note_playback #(
    parameter int ADDR_W = 6,
    parameter int DUR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   rec_len,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DUR_W+9:0]  mem_data,
    output logic [6:0]        note_out,
    output logic [2:0]        octave_out,
    output logic              playing,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W:0]   ptr, ptr_d;
    logic [ADDR_W:0]   len, len_d;
    logic [ADDR_W:0]   ptr_inc;
    logic [DUR_W-1:0]  cnt, cnt_d;
    logic [6:0]        note_d;
    logic [2:0]        oct_d;
    logic              end_step;
    logic              last_entry;

    logic [6:0]        entry_note;
    logic [2:0]        entry_oct;
    logic [DUR_W-1:0]  entry_dur;

    assign entry_note = mem_data[DUR_W+9:DUR_W+3];
    assign entry_oct  = mem_data[DUR_W+2:DUR_W];
    assign entry_dur  = mem_data[DUR_W-1:0];

    // One bit wider than the address so a full 2^ADDR_W recording compares correctly.
    assign ptr_inc    = ptr + (ADDR_W+1)'(1);
    assign last_entry = !(ptr_inc < len);
    assign mem_addr   = ptr[ADDR_W-1:0];

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latch).
        state_d  = state;
        ptr_d    = ptr;
        len_d    = len;
        cnt_d    = cnt;
        note_d   = note_out;
        oct_d    = octave_out;
        end_step = 1'b0;
        mem_rd   = 1'b0;
        playing  = 1'b1;
        done     = 1'b0;

        case (state)
            IDLE: begin
                playing = 1'b0;
                if (start && !stop) begin
                    len_d   = rec_len;
                    ptr_d   = '0;
                    state_d = (rec_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_rd  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (entry_dur != '0) begin
                    cnt_d   = entry_dur;
                    note_d  = entry_note;
                    oct_d   = entry_oct;
                    state_d = PLAY;
                end else begin
                    end_step = 1'b1;
                end
            end
            PLAY: begin
                // The tick that reaches zero ends the entry; the exit happens one edge later.
                if (cnt == '0) begin
                    end_step = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt - (DUR_W)'(1);
                end
            end
            DONE: begin
                playing = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (end_step) begin
            if (!last_entry) begin
                ptr_d   = ptr_inc;
                state_d = FETCH;
            end else if (loop_en) begin
                ptr_d   = '0;
                state_d = FETCH;
            end else begin
                state_d = DONE;
            end
        end

        // Abort wins over any end-of-entry step and leaves the last octave in place.
        if (stop && state != IDLE) begin
            state_d = IDLE;
            oct_d   = octave_out;
        end

        // Silence whenever playback is over; between entries the previous notes keep sounding.
        if (state_d inside {IDLE, DONE}) begin
            note_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            len        <= '0;
            cnt        <= '0;
            note_out   <= '0;
            octave_out <= '0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            len        <= len_d;
            cnt        <= cnt_d;
            note_out   <= note_d;
            octave_out <= oct_d;
        end
    end

endmodule

// File: tb/tb_note_playback.sv
// Self-checking bench for note_playback: per-cycle stimulus tables, an entry-level
// reference model that precomputes expected outputs, and a per-cycle compare process.
module tb_note_playback;

    localparam int ADDR_W = 6;
    localparam int DUR_W  = 8;
    localparam int N      = 320;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W:0]   rec_len;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DUR_W+9:0]  mem_data = '0;
    logic [6:0]        note_out;
    logic [2:0]        octave_out;
    logic              playing;
    logic              done;

    note_playback #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .rec_len    (rec_len),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .note_out   (note_out),
        .octave_out (octave_out),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Recording memory with one-cycle read latency.
    logic [DUR_W+9:0] mem [64];
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // Stimulus tables, indexed by cycle.
    bit in_tick [N];
    bit in_start[N];
    bit in_stop [N];
    bit in_rst  [N];
    bit in_loop [N];
    int in_len  [N];

    // Expected and observed outputs, indexed by cycle.
    bit         e_rd[N], e_play[N], e_done[N];
    int         e_addr[N];
    logic [6:0] e_note[N];
    logic [2:0] e_oct[N];
    bit         obs_rd[N], obs_play[N], obs_done[N];
    int         obs_addr[N];
    logic [6:0] obs_note[N];
    logic [2:0] obs_oct[N];

    logic [6:0] m_note;
    logic [2:0] m_oct;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int scen   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s scen %0d cycle %0d: got %0h, expected %0h", name, scen, cyc, act, exp);
        end
    endtask

    task automatic put(input int c, input bit rd, input int addr, input bit pl, input bit dn);
        if (c < N) begin
            e_rd[c]   = rd;
            e_addr[c] = addr;
            e_play[c] = pl;
            e_done[c] = dn;
            e_note[c] = m_note;
            e_oct[c]  = m_oct;
        end
    endtask

    // Reset or stop during playback: silent, back to idle next cycle.
    task automatic kill_at(input int c, output bit k);
        k = in_rst[c] || in_stop[c];
        if (k) begin
            m_note = '0;
            if (in_rst[c]) m_oct = '0;
        end
    endtask

    // Walk the recording entry by entry and lay down the expected per-cycle outputs.
    task automatic build_expected();
        int c, p, len, d, rem, last;
        bit k, aborted, ended;
        m_note = '0;
        m_oct  = '0;
        c      = 0;
        while (c < N) begin
            put(c, 0, 0, 0, 0);
            if (in_rst[c]) begin
                m_oct = '0;
                c++;
            end else if (in_start[c] && !in_stop[c]) begin
                len = in_len[c];
                p = 0;
                c++;
                aborted = 1'b0;
                ended   = (len == 0);
                while (!aborted && !ended && c < N) begin
                    put(c, 1, p, 1, 0);
                    kill_at(c, k);
                    c++;
                    if (k) begin aborted = 1'b1; break; end
                    if (c >= N) break;
                    put(c, 0, 0, 1, 0);
                    kill_at(c, k);
                    if (k) begin aborted = 1'b1; c++; break; end
                    d    = int'(mem[p][DUR_W-1:0]);
                    last = c;
                    if (d != 0) begin
                        m_note = mem[p][DUR_W+9:DUR_W+3];
                        m_oct  = mem[p][DUR_W+2:DUR_W];
                        rem    = d;
                        c++;
                        while (c < N) begin
                            put(c, 0, 0, 1, 0);
                            kill_at(c, k);
                            if (k) begin aborted = 1'b1; break; end
                            if (rem == 0) break;
                            if (in_tick[c]) rem--;
                            c++;
                        end
                        if (aborted) begin c++; break; end
                        if (c >= N) break;
                        last = c;
                    end
                    c = last + 1;
                    if (p + 1 < len) p++;
                    else if (in_loop[last]) p = 0;
                    else ended = 1'b1;
                end
                if (ended && c < N) begin
                    m_note = '0;
                    put(c, 0, 0, 0, 1);
                    kill_at(c, k);
                    c++;
                end
            end else begin
                c++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            obs_rd[cyc]   = mem_rd;
            obs_addr[cyc] = int'(mem_addr);
            obs_play[cyc] = playing;
            obs_done[cyc] = done;
            obs_note[cyc] = note_out;
            obs_oct[cyc]  = octave_out;
            check("mem_rd", 32'(mem_rd), 32'(e_rd[cyc]));
            if (e_rd[cyc]) check("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
            check("note_out", 32'(note_out), 32'(e_note[cyc]));
            check("octave_out", 32'(octave_out), 32'(e_oct[cyc]));
            check("playing", 32'(playing), 32'(e_play[cyc]));
            check("done", 32'(done), 32'(e_done[cyc]));
        end
    end

    task automatic clear_inputs();
        for (int t = 0; t < N; t++) begin
            in_tick[t]  = 1'b0;
            in_start[t] = 1'b0;
            in_stop[t]  = 1'b0;
            in_rst[t]   = 1'b0;
            in_loop[t]  = 1'b0;
            in_len[t]   = 0;
        end
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic periodic_ticks(input int period);
        for (int t = 0; t < N; t++) in_tick[t] = ((t % period) == period - 1);
    endtask

    task automatic set_len(input int len);
        for (int t = 0; t < N; t++) in_len[t] = len;
    endtask

    task automatic run_scenario();
        build_expected();
        @(posedge clk);
        #1;
        rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; rec_len = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        for (int t = 0; t < N; t++) begin
            cyc     = t;
            rst     = in_rst[t];
            tick    = in_tick[t];
            start   = in_start[t];
            stop    = in_stop[t];
            loop_en = in_loop[t];
            rec_len = (ADDR_W+1)'(in_len[t]);
            @(posedge clk);
            #1;
        end
        cmp_en = 1'b0;
        scen++;
    endtask

    function automatic int count_rd();
        int n = 0;
        for (int t = 0; t < N; t++) if (obs_rd[t]) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int t = 0; t < N; t++) if (obs_done[t]) n++;
        return n;
    endfunction

    task automatic load_two_entries();
        mem[0] = {7'b0000001, 3'd3, 8'd2};
        mem[1] = {7'b0000100, 3'd4, 8'd1};
    endtask

    task automatic gen_random(input bit longrun);
        int lm = $urandom_range(0, 2);
        clear_inputs();
        for (int i = 0; i < 64; i++) begin
            logic [7:0] d;
            d = longrun ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 4));
            mem[i] = {7'($urandom), 3'($urandom), d};
        end
        for (int t = 0; t < N; t++) begin
            in_tick[t]  = ($urandom_range(0, 2) == 0);
            in_start[t] = ($urandom_range(0, longrun ? 60 : 12) == 0);
            in_stop[t]  = ($urandom_range(0, longrun ? 400 : 70) == 0);
            in_rst[t]   = ($urandom_range(0, 300) == 0);
            in_loop[t]  = (lm == 2) ? 1'($urandom_range(0, 1)) : 1'(lm);
            in_len[t]   = longrun ? 64 : $urandom_range(0, 5);
        end
    endtask

    initial begin
        int tr;
        rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; rec_len = '0;

        // Two-entry recording, tick every 4 cycles.
        clear_inputs();
        load_two_entries();
        periodic_ticks(4);
        set_len(2);
        in_start[2] = 1'b1;
        run_scenario();
        check("lit_reset_note", 32'(obs_note[0]), 32'd0);
        check("lit_reset_play", 32'(obs_play[0]), 32'd0);
        check("lit_rd_first", 32'(obs_rd[3]), 32'd1);
        check("lit_addr_first", 32'(obs_addr[3]), 32'd0);
        check("lit_note_first", 32'(obs_note[5]), 32'h01);
        check("lit_note_hold", 32'(obs_note[13]), 32'h01);
        check("lit_rd_second", 32'(obs_rd[13]), 32'd1);
        check("lit_addr_second", 32'(obs_addr[13]), 32'd1);
        check("lit_note_second", 32'(obs_note[15]), 32'h04);
        check("lit_oct_second", 32'(obs_oct[15]), 32'd4);
        check("lit_done_cycle", 32'(obs_done[17]), 32'd1);
        check("lit_done_note", 32'(obs_note[17]), 32'd0);
        check("lit_done_count", 32'(count_done()), 32'd1);
        check("lit_idle_after", 32'(obs_play[18]), 32'd0);

        // Empty recording.
        clear_inputs();
        periodic_ticks(4);
        in_start[2] = 1'b1;
        run_scenario();
        check("lit_empty_done", 32'(obs_done[3]), 32'd1);
        check("lit_empty_rd", 32'(count_rd()), 32'd0);

        // Zero-duration middle entry is skipped.
        clear_inputs();
        mem[0] = {7'b0000011, 3'd2, 8'd1};
        mem[1] = {7'b1110000, 3'd5, 8'd0};
        mem[2] = {7'b0100000, 3'd6, 8'd2};
        periodic_ticks(2);
        set_len(3);
        in_start[2] = 1'b1;
        run_scenario();
        tr = 0;
        for (int t = 0; t < N - 1; t++) begin
            if (obs_note[t] == 7'b0000011 && obs_note[t+1] != 7'b0000011) begin
                tr++;
                check("lit_skip_next", 32'(obs_note[t+1]), 32'h20);
            end
        end
        check("lit_skip_trans", 32'(tr), 32'd1);

        // Looping single entry, stopped during PLAY.
        clear_inputs();
        mem[0] = {7'b1000000, 3'd1, 8'd1};
        periodic_ticks(1);
        set_len(1);
        for (int t = 0; t < N; t++) in_loop[t] = 1'b1;
        in_start[2] = 1'b1;
        in_stop[29] = 1'b1;
        run_scenario();
        check("lit_loop_rd", 32'(count_rd()), 32'd7);
        check("lit_loop_addr", 32'(obs_addr[27]), 32'd0);
        check("lit_loop_note", 32'(obs_note[29]), 32'h40);
        check("lit_stop_note", 32'(obs_note[30]), 32'd0);
        check("lit_stop_play", 32'(obs_play[30]), 32'd0);
        check("lit_loop_done", 32'(count_done()), 32'd0);

        // Reset during PLAY together with start and tick, then a fresh start.
        clear_inputs();
        load_two_entries();
        periodic_ticks(4);
        set_len(2);
        in_start[2] = 1'b1;
        in_rst[6] = 1'b1; in_start[6] = 1'b1; in_tick[6] = 1'b1;
        in_start[9] = 1'b1;
        run_scenario();
        check("lit_rst_oct", 32'(obs_oct[7]), 32'd0);
        check("lit_rst_note", 32'(obs_note[7]), 32'd0);
        check("lit_rst_play", 32'(obs_play[7]), 32'd0);
        check("lit_restart_rd", 32'(obs_rd[10]), 32'd1);
        check("lit_restart_addr", 32'(obs_addr[10]), 32'd0);

        // Start during PLAY and stop+start in IDLE are both ignored.
        clear_inputs();
        load_two_entries();
        periodic_ticks(4);
        set_len(2);
        in_start[2] = 1'b1;
        in_start[8] = 1'b1;
        in_start[25] = 1'b1; in_stop[25] = 1'b1;
        run_scenario();
        check("lit_restart_ign", 32'(obs_note[15]), 32'h04);
        check("lit_ign_done", 32'(obs_done[17]), 32'd1);
        check("lit_ign_rd", 32'(obs_rd[26]), 32'd0);
        check("lit_ign_play", 32'(obs_play[26]), 32'd0);

        // Full 64-entry recording, all skipped except the last.
        clear_inputs();
        mem[63] = {7'b0010000, 3'd7, 8'd1};
        periodic_ticks(1);
        set_len(64);
        in_start[2] = 1'b1;
        run_scenario();
        check("lit_full_rd", 32'(count_rd()), 32'd64);
        check("lit_full_addr", 32'(obs_addr[129]), 32'd63);
        check("lit_full_done", 32'(obs_done[133]), 32'd1);

        for (int s = 0; s < 24; s++) begin
            gen_random(s % 6 == 0);
            run_scenario();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
